ysyx_22040127_div_ctrl: RTL and testbench
=========================================

Name: ysyx_22040127_div_ctrl

Overview:
- Multi-cycle divide/remainder controller for the execute stage, replacing single-cycle combinational DIV/DIVU/REM/REMU and W-variant results.
- Sequences a radix-2 restoring shift-subtract datapath: operand preparation, iteration and sign/width fix-up.
- Connects to the execute stage through a valid/ready handshake. Execute holds its ready_go low until out_valid, matching the existing multiplier stall scheme.

Parameters:
- XLEN, 64, operand/result width; W-variants operate on the low 32 bits.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- flush  input  1  abort in-flight operation (pipeline redirect)
- in_valid  input  1  request valid
- in_ready  output  1  controller can accept a request
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- word  input  1  1 = W-variant (32-bit operate, sign-extend result)
- src1  input  XLEN  dividend
- src2  input  XLEN  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  quotient or remainder
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, PREP, CALC, FIX, DONE.
- Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch op, word, src1 and src2, then go to PREP.
- PREP (1 cycle):
  - W: operands truncated to [31:0]. Signed ops use sign-extension from bit 31; unsigned ops use zero-extension.
  - Signed ops: take absolute values. Record q_neg = sign1^sign2 and r_neg = sign1.
  - Load remainder=0, quotient=|dividend|, counter=N, where N=32 for W and XLEN otherwise.
- CALC (N cycles), each cycle:
  - Shift {rem,quo} left by 1.
  - Trial = rem - divisor. If trial is non-negative, rem=trial and quo[0]=1.
  - counter-1. Leave CALC when counter reaches 1.
- FIX (1 cycle):
  - Apply q_neg negation to the quotient and r_neg negation to the remainder.
  - Select by op[1].
  - W: sign-extend bit 31 to XLEN. This applies to DIVUW and REMUW as well.
  - Register the result.
- DONE:
  - out_valid=1; result is held stable.
  - Go to IDLE on out_ready. in_ready stays 0 during DONE; no same-cycle accept.
- Latency: out_valid asserts exactly N+3 cycles after the accepting edge (67 for 64-bit, 35 for W) when the special bypass is disabled.
- Special cases (RISC-V), always correct regardless of macro:
  - Divide by zero: quotient = all ones; remainder = dividend (sign-extended for W).
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
  - Divide-by-zero is detected in PREP and overrides the sign fix-up, so a negative dividend with divisor 0 still yields -1.
- flush:
  - Any state goes to IDLE next cycle; out_valid drops and no result is delivered.
  - flush has priority over out_ready and over a new in_valid in the same cycle.
  - A flush while IDLE with in_valid high does not accept the request.
- rst mid-operation: same as flush, plus result is cleared.
- out_ready held low: DONE persists indefinitely; result does not change.
- Registers update only on clk; there is no combinational path from in_* to out_*.

Optional Feature:
- Macro: YSYX_22040127_DIV_FASTPATH_EN.
- Defined: divide-by-zero or signed overflow is detected in PREP, which branches directly to DONE with the special result. out_valid asserts 2 cycles after acceptance.
- Defined: a dividend magnitude less than the divisor magnitude also takes the fast path (quotient 0, remainder = dividend), with the same 2-cycle latency.
- Undefined: all operations take the full N+3 cycles. Special results are substituted in FIX. Result values are identical in both builds.

Test Plan:
- DIV src1=-20 (0xFFFF_FFFF_FFFF_FFEC), src2=3 -> result 0xFFFF_FFFF_FFFF_FFFA (-6), out_valid exactly 67 cycles after accept (macro off).
- REMW src1=0x0000_0001_8000_0007, src2=2 -> result 0xFFFF_FFFF_FFFF_FFFF (-1); DIVUW with the same operands -> 0x0000_0000_4000_0003. Latency 35.
- DIV src1=-5, src2=0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU src1=7, src2=0 -> 7; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 and REM -> 0. Macro on: each completes in 2 cycles.
- Accept DIVU 100/7, assert flush in CALC cycle 10 -> out_valid never rises, busy=0 next cycle. A new DIVU 100/7 issued afterwards -> 14.
- Result 14 reached, out_ready held low 20 cycles -> out_valid=1 and result=14 stable, in_ready=0. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst in PREP with in_valid high -> next cycle state IDLE, result=0, out_valid=0, and the request is not accepted during the reset cycle.

Source files
------------

// File: rtl/ysyx_22040127_div_ctrl.sv
// Multi-cycle radix-2 restoring divide/remainder controller (DIV/DIVU/REM/REMU and W forms).
// Define YSYX_22040127_DIV_FASTPATH_EN to let special and trivial operands skip the iteration.
module ysyx_22040127_div_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   src1_q, src1_d, src2_q, src2_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept, is_signed, sign1, sign2, div_zero, overflow, ge;
  logic [XLEN-1:0]   a_ext, b_ext, abs_a, abs_b, min_val, quo_init;
  logic [XLEN-1:0]   q_sel, r_sel, res_pick, res_fmt;
  logic [XLEN:0]     shifted;
  logic [CNT_W-1:0]  n_iter;
`ifdef YSYX_22040127_DIV_FASTPATH_EN
  logic              small;
  assign small = abs_a < abs_b;
`endif

  assign accept = in_valid & in_ready & ~flush;

  // Operand preparation works off the latched request so it can be reused in FIX.
  always_comb begin
    is_signed = ~op_q[0];
    a_ext     = word_q ? {{(XLEN-32){is_signed & src1_q[31]}}, src1_q[31:0]} : src1_q;
    b_ext     = word_q ? {{(XLEN-32){is_signed & src2_q[31]}}, src2_q[31:0]} : src2_q;
    sign1     = is_signed & a_ext[XLEN-1];
    sign2     = is_signed & b_ext[XLEN-1];
    abs_a     = sign1 ? -a_ext : a_ext;
    abs_b     = sign2 ? -b_ext : b_ext;
    min_val   = word_q ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero  = (b_ext == '0);
    overflow  = is_signed & (a_ext == min_val) & (b_ext == '1);
    n_iter    = word_q ? CNT_W'(32) : CNT_W'(XLEN);
    // W dividends sit in the upper half so 32 shifts feed every bit into rem.
    quo_init  = word_q ? (abs_a << 32) : abs_a;
    shifted   = {rem_q, quo_q[XLEN-1]};
    ge        = shifted >= {1'b0, div_q};
  end

  always_comb begin
    q_sel = q_neg_q ? -quo_q : quo_q;
    r_sel = r_neg_q ? -rem_q : rem_q;
    if (div_zero) begin
      q_sel = '1;
      r_sel = a_ext;
    end else if (overflow) begin
      q_sel = a_ext;
      r_sel = '0;
    end
`ifdef YSYX_22040127_DIV_FASTPATH_EN
    else if (state_q == S_PREP) begin
      q_sel = '0;
      r_sel = a_ext;
    end
`endif
    res_pick = op_q[1] ? r_sel : q_sel;
    res_fmt  = word_q ? {{(XLEN-32){res_pick[31]}}, res_pick[31:0]} : res_pick;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_PREP;
      S_PREP: begin
`ifdef YSYX_22040127_DIV_FASTPATH_EN
        if (div_zero | overflow | small) state_d = S_DONE;
        else                             state_d = S_CALC;
`else
        state_d = S_CALC;
`endif
      end
      S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    result    = result_q;
  end

  always_comb begin
    op_d     = op_q;
    word_d   = word_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d   = op;
        word_d = word;
        src1_d = src1;
        src2_d = src2;
      end
      S_PREP: begin
        rem_d   = '0;
        quo_d   = quo_init;
        div_d   = abs_b;
        cnt_d   = n_iter;
        q_neg_d = sign1 ^ sign2;
        r_neg_d = sign1;
`ifdef YSYX_22040127_DIV_FASTPATH_EN
        if ((div_zero | overflow | small) && !flush) result_d = res_fmt;
`endif
      end
      S_CALC: begin
        quo_d = {quo_q[XLEN-2:0], ge};
        rem_d = ge ? (shifted[XLEN-1:0] - div_q) : shifted[XLEN-1:0];
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_FIX: if (!flush) result_d = res_fmt;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      word_q   <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      word_q   <= word_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22040127_div_ctrl.sv
// Directed bench for ysyx_22040127_div_ctrl: arithmetic reference model plus latency/handshake checks.
`timescale 1ns/1ps
module tb_ysyx_22040127_div_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic        word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          phase = 3;   // 0 idle, 1 awaiting result, 2 holding result, 3 not monitored
  int          cyc = 0;
  int          exp_lat = 0;
  logic [63:0] exp_res = '0;

  ysyx_22040127_div_ctrl #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {63'b0, act}, {63'b0, exp});
  endtask

  // RISC-V division semantics computed with native signed/unsigned arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic        rem_op, sgn;
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    rem_op = o[1];
    sgn    = ~o[0];
    a32    = a[31:0];
    b32    = b[31:0];
    if (w) begin
      if (b32 == 32'h0)                                       r32 = rem_op ? a32 : 32'hFFFF_FFFF;
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem_op ? 32'h0 : a32;
      else if (sgn) r32 = rem_op ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      else          r32 = rem_op ? (a32 % b32) : (a32 / b32);
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'h0)                                                       r64 = rem_op ? a : '1;
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = rem_op ? 64'h0 : a;
    else if (sgn) r64 = rem_op ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    else          r64 = rem_op ? (a % b) : (a / b);
    return r64;
  endfunction

  function automatic int lat_model(input logic [1:0] o, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
`ifdef YSYX_22040127_DIV_FASTPATH_EN
    logic dz, ovf, zero_q;
    dz     = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    ovf    = ~o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == '1));
    zero_q = (model({1'b0, o[0]}, w, a, b) == 64'h0);
    if (dz || ovf || zero_q) return 2;
`endif
    return w ? 35 : 67;
  endfunction

  // Single compare process: checks outputs every cycle against the expected phase.
  always @(negedge clk) begin
    case (phase)
      0: check1("idle_out_valid", out_valid, 1'b0);
      1: begin
        if (out_valid) begin
          check("latency", 64'(cyc), 64'(exp_lat));
          check("result", result, exp_res);
          check1("done_in_ready", in_ready, 1'b0);
          phase = out_ready ? 0 : 2;
        end else if (cyc >= exp_lat + 4) begin
          checks++;
          errors++;
          $display("FAIL out_valid_timeout: got no out_valid after %0d cycles, required at %0d", cyc, exp_lat);
          phase = 0;
        end else begin
          cyc++;
        end
      end
      2: begin
        check1("hold_out_valid", out_valid, 1'b1);
        check("hold_result", result, exp_res);
        check1("hold_in_ready", in_ready, 1'b0);
        if (out_ready) phase = 0;
      end
      default: ;
    endcase
  end

  task automatic issue(input string name, input logic [1:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] lit);
    check({name, "_model"}, model(o, w, a, b), lit);
    op = o; word = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_res  = model(o, w, a, b);
    exp_lat  = lat_model(o, w, a, b);
    cyc      = 1;
    phase    = 1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && phase == 1; i++) @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic w,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] lit);
    issue(name, o, w, a, b, lit);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check("rst_result", result, 64'h0);
    rst   = 1'b0;
    phase = 0;
    @(posedge clk); #1;

    op = 2'b01; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check1("flush_idle_no_accept", busy, 1'b0);

    run("div_neg20_3",  2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    run("remw_odd",     2'b10, 1'b1, 64'h0000_0001_8000_0007, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run("divuw_odd",    2'b01, 1'b1, 64'h0000_0001_8000_0007, 64'd2, 64'h0000_0000_4000_0003);
    run("div_by_zero",  2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run("remu_by_zero", 2'b11, 1'b0, 64'd7, 64'd0, 64'd7);
    run("div_ovf",      2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    run("rem_ovf",      2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    run("divw_ovf",     2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    run("remw_ovf",     2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0);
    run("divw_by_zero", 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run("remw_by_zero", 2'b10, 1'b1, 64'h0000_0001_0000_0005, 64'h0000_0001_0000_0000, 64'd5);
    run("remuw",        2'b11, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd7, 64'd2);
    run("divuw_sext",   2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    run("rem_neg7_2",   2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run("div_100_m7",   2'b00, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2);
    run("rem_100_m7",   2'b10, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    run("divu_big",     2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'h1999_9999_9999_9999);
    run("remu_big",     2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5);
    run("divu_small",   2'b01, 1'b0, 64'd3, 64'd10, 64'd0);

    issue("flush_divu", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    phase = 0;
    @(posedge clk); #1;
    flush = 1'b0;
    check1("flush_busy", busy, 1'b0);
    check1("flush_in_ready", in_ready, 1'b1);
    check1("flush_out_valid", out_valid, 1'b0);
    repeat (80) @(posedge clk);
    #1;
    run("after_flush_divu", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14);

    out_ready = 1'b0;
    issue("hold_divu", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14);
    for (int i = 0; i < 200 && phase == 1; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    check1("held_out_valid", out_valid, 1'b1);
    check("held_result", result, 64'd14);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check1("release_in_ready", in_ready, 1'b1);
    check1("release_busy", busy, 1'b0);

    issue("rst_div", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    rst = 1'b1; in_valid = 1'b1; op = 2'b01; src1 = 64'd9; src2 = 64'd3;
    phase = 0;
    @(posedge clk); #1;
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_in_ready", in_ready, 1'b1);
    check1("midrst_out_valid", out_valid, 1'b0);
    check("midrst_result", result, 64'h0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check1("midrst_no_accept", busy, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
